// File: rtl/lcd_init_seq_pkg.sv
// Shared definitions for the HD44780 LCD init sequencer and the button-side
// writer: command bytes, sequencer state encoding and a small helper.
package lcd_init_seq_pkg;

  // HD44780 instruction bytes used during 8-bit initialisation.
  localparam logic [7:0] LCD_FUNC_SET_8B = 8'h38;
  localparam logic [7:0] LCD_DISP_ON     = 8'h0C;
  localparam logic [7:0] LCD_CLEAR       = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC   = 8'h06;

  // Index of the last entry in the command table.
  localparam logic [2:0] CMD_LAST = 3'd6;

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_SETUP   = 3'd1,
    S_EHIGH   = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by the LCD init sequencer and the button-side
// LCD writer. load takes priority; the count parks at zero and never wraps.
module lcd_delay_cnt #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Count register: reload on request, otherwise decrement until zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values,
      // so the order of sequential blocks cannot change behaviour.
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_init_seq.sv
// Power-up initialisation sequencer for an HD44780 LCD in 8-bit mode. Walks a
// fixed seven-entry command table, strobing E with setup/high/wait timing, then
// raises init_complete_flag to hand the bus to the user path.
module lcd_init_seq
  import lcd_init_seq_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_E_SETUP = 2,
  parameter int unsigned T_E_HIGH  = 12,
  parameter int unsigned T_WAKE1   = 205000,
  parameter int unsigned T_WAKE2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       RW_init_lcd,
  output logic       RS_init_lcd,
  output logic [7:0] data_init_lcd,
  output logic       E_init_lcd,
  output logic       init_complete_flag
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_POWERUP, T_E_SETUP), max_u(T_E_HIGH, T_WAKE1)),
                                        max_u(max_u(T_WAKE2, T_CMD), T_CLEAR));

  // Elaboration-time guards: the counter must hold every delay, and no delay may be zero.
  if ((64'd1 << CNT_W) <= 64'(T_MAX)) begin : g_cnt_w_chk
    $error("lcd_init_seq: CNT_W=%0d cannot hold delay %0d", CNT_W, T_MAX);
  end
  if (T_POWERUP == 0 || T_E_SETUP == 0 || T_E_HIGH == 0 || T_WAKE1 == 0 ||
      T_WAKE2 == 0 || T_CMD == 0 || T_CLEAR == 0) begin : g_zero_chk
    $error("lcd_init_seq: every T_* delay must be at least 1");
  end

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             armed;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic [7:0]       data_nxt;

  // Command ROM: instruction byte for each table entry.
  function automatic logic [7:0] cmd_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2, 3'd3: return LCD_FUNC_SET_8B;
      3'd4:                   return LCD_DISP_ON;
      3'd5:                   return LCD_CLEAR;
      3'd6:                   return LCD_ENTRY_INC;
      default:                return 8'h00;
    endcase
  endfunction

  // Post-command wait ROM, pre-decremented for the counter's load convention.
  function automatic logic [CNT_W-1:0] wait_len(input logic [2:0] i);
    case (i)
      3'd0:    return CNT_W'(T_WAKE1 - 1);
      3'd1:    return CNT_W'(T_WAKE2 - 1);
      3'd5:    return CNT_W'(T_CLEAR - 1);
      default: return CNT_W'(T_CMD - 1);
    endcase
  endfunction

  lcd_delay_cnt #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Next-state, table index and delay-load decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    idx_nxt   = idx;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      S_POWERUP: begin
        // The counter comes out of reset at zero, so the power-up delay is
        // loaded on the first cycle and only then allowed to expire.
        if (!armed) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_POWERUP - 1);
        end else if (cnt_done) begin
          state_nxt = S_SETUP;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(T_E_SETUP - 1);
        end
      end
      S_SETUP: if (cnt_done) begin
        state_nxt = S_EHIGH;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(T_E_HIGH - 1);
      end
      S_EHIGH: if (cnt_done) begin
        state_nxt = S_WAIT;
        cnt_load  = 1'b1;
        cnt_val   = wait_len(idx);
      end
      S_WAIT: if (cnt_done) begin
        if (idx == CMD_LAST) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SETUP;
          idx_nxt   = idx + 3'd1;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(T_E_SETUP - 1);
        end
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_POWERUP;
    endcase
  end

  // Bus data follows the command while it is being set up, strobed and held.
  always_comb begin
    data_nxt = 8'h00;
    if (state_nxt == S_SETUP || state_nxt == S_EHIGH || state_nxt == S_WAIT) begin
      data_nxt = cmd_byte(idx_nxt);
    end
  end

  // Sequencer state, table index and power-up arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_POWERUP;
      idx   <= 3'd0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == S_POWERUP) armed <= 1'b1;
    end
  end

  // Registered LCD outputs, decoded from the next state so they change on the
  // same edge as the state and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_init_lcd      <= 8'h00;
      E_init_lcd         <= 1'b0;
      init_complete_flag <= 1'b0;
    end else begin
      data_init_lcd      <= data_nxt;
      E_init_lcd         <= (state_nxt == S_EHIGH);
      init_complete_flag <= (state_nxt == S_DONE);
    end
  end

  // Initialisation only ever writes instructions.
  assign RW_init_lcd = 1'b0;
  assign RS_init_lcd = 1'b0;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq with shortened delays: reset hold, full
// sequence timing, async reset mid-strobe, post-done stability and the
// downstream Mux21 handover.
module tb_lcd_init_seq;

  logic       clk;
  logic       rst_n;
  logic       rw, rs, e, flag;
  logic [7:0] data;

  // Stand-in for the downstream Mux21 with fixed button-path stimulus.
  logic       btn_rs, btn_e;
  logic [7:0] btn_data;
  logic       mux_rs, mux_e;
  logic [7:0] mux_data;

  assign btn_rs   = 1'b1;
  assign btn_e    = 1'b1;
  assign btn_data = 8'hFF;
  assign mux_rs   = flag ? btn_rs   : rs;
  assign mux_e    = flag ? btn_e    : e;
  assign mux_data = flag ? btn_data : data;

  lcd_init_seq #(
    .T_POWERUP (100),
    .T_E_SETUP (2),
    .T_E_HIGH  (4),
    .T_WAKE1   (50),
    .T_WAKE2   (20),
    .T_CMD     (10),
    .T_CLEAR   (30),
    .CNT_W     (20)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .RW_init_lcd        (rw),
    .RS_init_lcd        (rs),
    .data_init_lcd      (data),
    .E_init_lcd         (e),
    .init_complete_flag (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  int         rise_cyc[$];
  int         fall_cyc[$];
  logic [7:0] rise_data[$];
  int         flag_cyc;
  int         stab_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge; cyc is the edge index.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Deassert reset between edges so the next edge is cycle 0.
  task automatic release_reset();
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  // Step until the flag rises (or the budget runs out), logging E pulses and
  // any data movement inside the setup..fall window.
  task automatic run_until_flag(input int budget);
    logic       prev_e;
    logic [7:0] d1, d2, dpulse;
    rise_cyc.delete();
    fall_cyc.delete();
    rise_data.delete();
    flag_cyc = -1;
    stab_err = 0;
    prev_e   = 1'b0;
    d1       = 8'h00;
    d2       = 8'h00;
    dpulse   = 8'h00;
    for (int n = 0; n < budget && flag_cyc < 0; n++) begin
      step();
      if (e && !prev_e) begin
        rise_cyc.push_back(cyc);
        rise_data.push_back(data);
        if (d1 !== data || d2 !== data) stab_err++;
        dpulse = data;
      end
      if (e && data !== dpulse) stab_err++;
      if (!e && prev_e) begin
        fall_cyc.push_back(cyc);
        if (data !== dpulse) stab_err++;
      end
      if (flag === 1'b1) flag_cyc = cyc;
      d2     = d1;
      d1     = data;
      prev_e = e;
    end
  endtask

  logic [7:0] exp_data[7];
  int         exp_gap[6];

  initial begin
    int bad;
    int pulses;
    logic prev_e;
    logic hit;

    exp_data = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    exp_gap  = '{52, 22, 12, 12, 12, 32};

    // Reset hold: outputs stay at reset values for 50 cycles.
    rst_n = 1'b1;
    cyc   = 0;
    #3 rst_n = 1'b0;
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (e !== 1'b0 || rs !== 1'b0 || rw !== 1'b0 || data !== 8'h00 || flag !== 1'b0) bad++;
    end
    check("reset_hold_violations", bad, 0);
    check("reset_outputs", {rw, rs, e, flag, data}, 12'h000);
    check("mux_during_reset", {mux_rs, mux_e, mux_data}, 10'h000);

    // Full sequence.
    release_reset();
    run_until_flag(400);
    check("first_rise_cycle", rise_cyc[0], 102);
    check("first_rise_data", rise_data[0], 8'h38);
    check("pulse_count", rise_cyc.size(), 7);
    check("fall_count", fall_cyc.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("pulse%0d_data", i), rise_data[i], exp_data[i]);
      check($sformatf("pulse%0d_width", i), fall_cyc[i] - rise_cyc[i], 4);
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("gap%0d", i), rise_cyc[i+1] - fall_cyc[i], exp_gap[i]);
    end
    check("data_stability", stab_err, 0);
    check("flag_cycle", flag_cyc, 282);

    // Post-done stability and Mux21 handover.
    bad    = 0;
    pulses = 0;
    prev_e = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      step();
      if (flag !== 1'b1 || e !== 1'b0 || data !== 8'h00) bad++;
      if (e && !prev_e) pulses++;
      prev_e = e;
    end
    check("post_done_violations", bad, 0);
    check("post_done_pulses", pulses, 0);
    check("post_done_outputs", {flag, e, data}, 10'h200);
    check("mux_after_flag", {mux_rs, mux_e, mux_data}, 10'h3FF);

    // Async reset in the middle of the command-4 strobe.
    rst_n = 1'b0;
    step();
    step();
    release_reset();
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      step();
      if (e === 1'b1 && data === 8'h0C) hit = 1'b1;
    end
    check("cmd4_strobe_seen", hit, 1'b1);
    check("mux_follows_init", {mux_e, mux_data}, 9'h10C);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_e", e, 1'b0);
    check("async_reset_data", data, 8'h00);
    check("async_reset_flag", flag, 1'b0);
    step();
    step();
    step();
    release_reset();
    run_until_flag(400);
    check("restart_first_rise", rise_cyc[0], 102);
    check("restart_first_data", rise_data[0], 8'h38);
    check("restart_flag_cycle", flag_cyc, 282);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
